// File: rtl/sram_word_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_word_arbiter_if
// Brief    : Per-port request/return bus plus SRAM controller word bus.
//            slave = arbiter view, master = requesters + controller view.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_word_arbiter_if #(
    parameter int NPORTS = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [NPORTS-1:0]        p_wr;
    logic [NPORTS-1:0]        p_rd;
    logic [NPORTS*ADDR_W-1:0] p_addr;
    logic [NPORTS*DATA_W-1:0] p_wdata;
    logic [NPORTS*STRB_W-1:0] p_wstrb;
    logic [NPORTS-1:0]        p_busy;
    logic [DATA_W-1:0]        p_rdata;
    logic [NPORTS-1:0]        p_rvalid;

    logic                     sram_wr;
    logic                     sram_rd;
    logic [ADDR_W-1:0]        sram_addr;
    logic [DATA_W-1:0]        sram_wdata;
    logic [STRB_W-1:0]        sram_wstrb;
    logic [DATA_W-1:0]        sram_rdata;
    logic                     sram_busy;

    modport master (
        output p_wr, p_rd, p_addr, p_wdata, p_wstrb, sram_rdata, sram_busy,
        input  p_busy, p_rdata, p_rvalid,
        input  sram_wr, sram_rd, sram_addr, sram_wdata, sram_wstrb
    );

    modport slave (
        input  p_wr, p_rd, p_addr, p_wdata, p_wstrb, sram_rdata, sram_busy,
        output p_busy, p_rdata, p_rvalid,
        output sram_wr, sram_rd, sram_addr, sram_wdata, sram_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/sram_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_word_arbiter
// Brief    : Shares one SRAM controller word interface among NPORTS requesters.
//            Macro SRAM_ARB_RR_EN selects round-robin; default is fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_word_arbiter #(
    parameter int NPORTS = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    sram_word_arbiter_if.slave bus,
    output logic [2:0]         grant_id,
    output logic               active
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;

    logic [NPORTS-1:0] pending_q;
    logic [NPORTS-1:0] pending_d;
    logic [NPORTS-1:0] cap;
    logic [NPORTS-1:0] clr_mask;

    logic [ADDR_W-1:0] slot_addr_q  [NPORTS];
    logic [DATA_W-1:0] slot_wdata_q [NPORTS];
    logic [STRB_W-1:0] slot_wstrb_q [NPORTS];
    logic              slot_wr_q    [NPORTS];

    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic              issue;
    logic              complete;

    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  grant_d;
    logic [NPORTS-1:0] grant_onehot;
    logic              seen_busy_q;
    logic              seen_busy_d;

    logic              sram_wr_q;
    logic              sram_wr_d;
    logic              sram_rd_q;
    logic              sram_rd_d;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [ADDR_W-1:0] sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [DATA_W-1:0] sram_wdata_d;
    logic [STRB_W-1:0] sram_wstrb_q;
    logic [STRB_W-1:0] sram_wstrb_d;
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] p_rdata_d;
    logic [NPORTS-1:0] p_rvalid_q;
    logic [NPORTS-1:0] p_rvalid_d;

    // ------------------------------------------------------------------
    // Request capture: a port with a live request ignores further pulses.
    // ------------------------------------------------------------------
    assign cap          = (bus.p_wr | bus.p_rd) & ~pending_q;
    assign grant_onehot = NPORTS'(1) << grant_q;
    assign clr_mask     = complete ? grant_onehot : '0;
    assign pending_d    = (pending_q & ~clr_mask) | cap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                slot_wstrb_q[i] <= '0;
                slot_wr_q[i]    <= 1'b0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NPORTS; i++) begin
                if (cap[i]) begin
                    slot_addr_q[i]  <= bus.p_addr[i*ADDR_W +: ADDR_W];
                    slot_wdata_q[i] <= bus.p_wdata[i*DATA_W +: DATA_W];
                    slot_wstrb_q[i] <= bus.p_wstrb[i*STRB_W +: STRB_W];
                    // Write takes precedence when both pulses arrive together.
                    slot_wr_q[i]    <= bus.p_wr[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    int               cand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (issue) begin
            rr_ptr_q <= win_idx;
        end
    end

    // Search begins one past the last granted port and wraps.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = (int'(rr_ptr_q) + k) % NPORTS;
            if (!win_valid && pending_q[IDX_W'(cand)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (pending_q[IDX_W'(k)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid && !bus.sram_busy) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion needs a busy period first; the issue cycle itself is not one.
                if (seen_busy_q && !bus.sram_busy) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registered through the _q stage below)
    // ------------------------------------------------------------------
    always_comb begin
        sram_wr_d    = issue &  slot_wr_q[win_idx];
        sram_rd_d    = issue & ~slot_wr_q[win_idx];
        sram_addr_d  = issue ? slot_addr_q[win_idx]  : sram_addr_q;
        sram_wdata_d = issue ? slot_wdata_q[win_idx] : sram_wdata_q;
        sram_wstrb_d = issue ? slot_wstrb_q[win_idx] : sram_wstrb_q;
        grant_d      = issue ? win_idx : grant_q;

        seen_busy_d  = seen_busy_q;
        if (issue) begin
            seen_busy_d = 1'b0;
        end else if (state_q == ST_WAIT && bus.sram_busy) begin
            seen_busy_d = 1'b1;
        end

        p_rvalid_d = '0;
        p_rdata_d  = p_rdata_q;
        if (complete && !slot_wr_q[grant_q]) begin
            p_rvalid_d = grant_onehot;
            p_rdata_d  = bus.sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_wr_q    <= 1'b0;
            sram_rd_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_wstrb_q <= '0;
            grant_q      <= '0;
            seen_busy_q  <= 1'b0;
            p_rvalid_q   <= '0;
            p_rdata_q    <= '0;
        end else begin
            sram_wr_q    <= sram_wr_d;
            sram_rd_q    <= sram_rd_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_wstrb_q <= sram_wstrb_d;
            grant_q      <= grant_d;
            seen_busy_q  <= seen_busy_d;
            p_rvalid_q   <= p_rvalid_d;
            p_rdata_q    <= p_rdata_d;
        end
    end

    assign bus.sram_wr    = sram_wr_q;
    assign bus.sram_rd    = sram_rd_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.sram_wstrb = sram_wstrb_q;
    assign bus.p_busy     = pending_q;
    assign bus.p_rdata    = p_rdata_q;
    assign bus.p_rvalid   = p_rvalid_q;

    assign grant_id = 3'(grant_q);
    assign active   = (|pending_q) | (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_word_arbiter
// Brief    : Scoreboard bench for sram_word_arbiter with a latency-driven
//            SRAM controller model. Build with SRAM_ARB_RR_EN to cover round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_word_arbiter;
    localparam int NP = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        int          port;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } iss_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_t;

    logic       clk;
    logic       reset;
    logic [2:0] grant_id;
    logic       active;

    iss_t iss_q[$];
    rd_t  rd_q[$];
    int   n_checks;
    int   n_errors;
    int   lat;
    int   recov;
    int   n0;

    sram_word_arbiter_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_word_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] rd_pattern(input logic [15:0] a);
        if (a == 16'h0200) return 32'h1234_5678;
        return {~a, a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: busy for lat cycles after a pulse, then optionally a
    // single low cycle followed by recov cycles of recovery busy.
    logic [31:0] m_rdata;
    logic        m_busy;
    logic        m_gap;
    int          m_cnt;
    int          m_rc;

    assign bus.sram_busy  = m_busy;
    assign bus.sram_rdata = m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_gap   <= 1'b0;
            m_cnt   <= 0;
            m_rc    <= 0;
            m_rdata <= '0;
        end else if (bus.sram_wr || bus.sram_rd) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            if (bus.sram_rd) m_rdata <= rd_pattern(bus.sram_addr);
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_gap  <= (recov > 0);
        end else if (m_gap) begin
            m_gap  <= 1'b0;
            m_busy <= 1'b1;
            m_rc   <= recov;
        end else if (m_rc > 1) begin
            m_rc <= m_rc - 1;
        end else if (m_rc == 1) begin
            m_rc   <= 0;
            m_busy <= 1'b0;
        end
    end

    // Scoreboard: controller-side issues
    always @(negedge clk) begin
        if (!reset && (bus.sram_wr || bus.sram_rd)) begin
            if (iss_q.size() == 0) begin
                check_eq("unexp_issue", {bus.sram_wr, bus.sram_rd}, 2'b00);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                check_eq("iss_port", grant_id, e.port);
                check_eq("iss_dir", {bus.sram_wr, bus.sram_rd}, e.wr ? 2'b10 : 2'b01);
                check_eq("iss_addr", bus.sram_addr, e.addr);
                if (e.wr) begin
                    check_eq("iss_wdata", bus.sram_wdata, e.wdata);
                    check_eq("iss_wstrb", bus.sram_wstrb, e.strb);
                end
            end
        end
    end

    // Scoreboard: read returns
    always @(negedge clk) begin
        if (!reset && bus.p_rvalid != '0) begin
            if (rd_q.size() == 0) begin
                check_eq("unexp_rvalid", bus.p_rvalid, 0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                check_eq("rv_onehot", bus.p_rvalid, 3'b001 << r.port);
                check_eq("rv_rdata", bus.p_rdata, r.data);
                check_eq("rv_busy_fall", bus.p_busy[r.port], 0);
            end
        end
    end

    task automatic set_port(input int p, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bus.p_addr[p*AW +: AW]  = a;
        bus.p_wdata[p*DW +: DW] = d;
        bus.p_wstrb[p*SW +: SW] = s;
    endtask

    task automatic exp_iss(input int p, input bit wr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s, input bit want_rv);
        iss_t e;
        rd_t  r;
        e.port = p; e.wr = wr; e.addr = a; e.wdata = d; e.strb = s;
        iss_q.push_back(e);
        if (!wr && want_rv) begin
            r.port = p;
            r.data = rd_pattern(a);
            rd_q.push_back(r);
        end
    endtask

    task automatic pulse(input logic [NP-1:0] wr, input logic [NP-1:0] rd);
        @(posedge clk);
        #1;
        bus.p_wr = wr;
        bus.p_rd = rd;
        @(posedge clk);
        #1;
        bus.p_wr = '0;
        bus.p_rd = '0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!active && !bus.sram_busy && m_cnt == 0 && m_rc == 0 && !m_gap) ok = 1'b1;
        end
        if (!ok) check_eq({tag, "_idle_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_busy(input bit level, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.sram_busy == level) ok = 1'b1;
        end
        if (!ok) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        lat       = 3;
        recov     = 0;
        reset     = 1'b1;
        bus.p_wr    = '0;
        bus.p_rd    = '0;
        bus.p_addr  = '0;
        bus.p_wdata = '0;
        bus.p_wstrb = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_busy", bus.p_busy, 0);
        check_eq("rst_rvalid", bus.p_rvalid, 0);
        check_eq("rst_sram_pulse", {bus.sram_wr, bus.sram_rd}, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_addr", bus.sram_addr, 0);
        check_eq("rst_rdata", bus.p_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single write on port 1 with busy timing
        set_port(1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        exp_iss(1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        pulse(3'b010, 3'b000);
        @(negedge clk);
        check_eq("t1_busy_set", bus.p_busy, 3'b010);
        check_eq("t1_active", active, 1);
        wait_busy(1'b1, "t1_busy_rise");
        wait_busy(1'b0, "t1_busy_fall");
        check_eq("t1_busy_hold", bus.p_busy[1], 1);
        @(negedge clk);
        check_eq("t1_busy_clr", bus.p_busy[1], 0);
        wait_idle("t1");

        // 2: read on port 0
        set_port(0, 16'h0200, 32'h0, 4'h0);
        exp_iss(0, 1'b0, 16'h0200, 32'h0, 4'h0, 1'b1);
        pulse(3'b000, 3'b001);
        wait_idle("t2");
        check_eq("t2_rdata_hold", bus.p_rdata, 32'h1234_5678);

        // 3: all ports request in the same cycle
        for (int p = 0; p < NP; p++) set_port(p, 16'h0030 + 16'(p), 32'h3000_0000 + 32'(p), 4'hF);
`ifdef SRAM_ARB_RR_EN
        exp_iss(1, 1'b1, 16'h0031, 32'h3000_0001, 4'hF, 1'b0);
        exp_iss(2, 1'b1, 16'h0032, 32'h3000_0002, 4'hF, 1'b0);
        exp_iss(0, 1'b1, 16'h0030, 32'h3000_0000, 4'hF, 1'b0);
`else
        exp_iss(0, 1'b1, 16'h0030, 32'h3000_0000, 4'hF, 1'b0);
        exp_iss(1, 1'b1, 16'h0031, 32'h3000_0001, 4'hF, 1'b0);
        exp_iss(2, 1'b1, 16'h0032, 32'h3000_0002, 4'hF, 1'b0);
`endif
        pulse(3'b111, 3'b000);
        @(negedge clk);
        check_eq("t3_busy_all", bus.p_busy, 3'b111);
        wait_idle("t3");
`ifdef SRAM_ARB_RR_EN
        check_eq("t3_last_grant", grant_id, 0);
`else
        check_eq("t3_last_grant", grant_id, 2);
`endif

        // 4: port 0 re-requests whenever free while port 2 waits
        recov = 1;
        n0    = 0;
`ifdef SRAM_ARB_RR_EN
        exp_iss(0, 1'b1, 16'h0400, 32'hA000_0000, 4'hF, 1'b0);
        exp_iss(2, 1'b1, 16'h0500, 32'hC0DE_0002, 4'hC, 1'b0);
        for (int k = 1; k < 4; k++) exp_iss(0, 1'b1, 16'h0400 + 16'(k), 32'hA000_0000 + 32'(k), 4'hF, 1'b0);
`else
        for (int k = 0; k < 4; k++) exp_iss(0, 1'b1, 16'h0400 + 16'(k), 32'hA000_0000 + 32'(k), 4'hF, 1'b0);
        exp_iss(2, 1'b1, 16'h0500, 32'hC0DE_0002, 4'hC, 1'b0);
`endif
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            bus.p_wr = '0;
            if (c == 1) begin
                set_port(2, 16'h0500, 32'hC0DE_0002, 4'hC);
                bus.p_wr[2] = 1'b1;
            end
            if (!bus.p_busy[0] && n0 < 4) begin
                set_port(0, 16'h0400 + 16'(n0), 32'hA000_0000 + 32'(n0), 4'hF);
                bus.p_wr[0] = 1'b1;
                n0++;
            end
        end
        bus.p_wr = '0;
        wait_idle("t4");
        recov = 0;
        wait_idle("t4b");

        // 5: request while busy is ignored; wr+rd together is a write
        set_port(1, 16'h0050, 32'h1111_1111, 4'hF);
        exp_iss(1, 1'b1, 16'h0050, 32'h1111_1111, 4'hF, 1'b0);
        pulse(3'b010, 3'b000);
        check_eq("t5_busy_before_dup", bus.p_busy[1], 1);
        set_port(1, 16'h0051, 32'h2222_2222, 4'h3);
        pulse(3'b010, 3'b000);
        wait_idle("t5a");
        set_port(1, 16'h0052, 32'h3333_3333, 4'h5);
        exp_iss(1, 1'b1, 16'h0052, 32'h3333_3333, 4'h5, 1'b0);
        pulse(3'b010, 3'b010);
        wait_idle("t5b");

        // 6: reset while a grant is in flight with two ports pending
        set_port(0, 16'h0060, 32'h0, 4'h0);
        set_port(1, 16'h0061, 32'h0, 4'h0);
        exp_iss(0, 1'b0, 16'h0060, 32'h0, 4'h0, 1'b0);
        pulse(3'b000, 3'b011);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.sram_rd) seen = 1'b1;
            end
            if (!seen) check_eq("t6_issue_timeout", 0, 1);
        end
        @(negedge clk);
        check_eq("t6_pre_busy", bus.p_busy, 3'b011);
        check_eq("t6_pre_active", active, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_busy", bus.p_busy, 0);
        check_eq("t6_rst_active", active, 0);
        check_eq("t6_rst_rvalid", bus.p_rvalid, 0);
        check_eq("t6_rst_grant", grant_id, 0);
        repeat (2) @(negedge clk);
        check_eq("t6_hold_rvalid", bus.p_rvalid, 0);
        reset = 1'b0;
        set_port(2, 16'h0070, 32'h7777_0000, 4'h9);
        exp_iss(2, 1'b1, 16'h0070, 32'h7777_0000, 4'h9, 1'b0);
        pulse(3'b100, 3'b000);
        wait_idle("t6a");
        set_port(1, 16'h0071, 32'h0, 4'h0);
        exp_iss(1, 1'b0, 16'h0071, 32'h0, 4'h0, 1'b1);
        pulse(3'b000, 3'b010);
        wait_idle("t6b");
        check_eq("t6_rdata_after", bus.p_rdata, rd_pattern(16'h0071));

        check_eq("sb_iss_drain", iss_q.size(), 0);
        check_eq("sb_rd_drain", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
